// File: rtl/button_press_classifier_if.sv
// Bundles the debouncer edge pulses and the classifier results.
// The master side (debouncer / bench) drives the edges.
// The slave side (classifier) drives the gesture results.
interface button_press_classifier_if;
   logic p_edge;
   logic n_edge;
   logic short_press;
   logic long_press;
   logic double_click;
   logic held;
   logic busy;

   modport master (
      output p_edge,
      output n_edge,
      input  short_press,
      input  long_press,
      input  double_click,
      input  held,
      input  busy
   );

   modport slave (
      input  p_edge,
      input  n_edge,
      output short_press,
      output long_press,
      output double_click,
      output held,
      output busy
   );
endinterface

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short press, long press or double click.
// Each classification is a one-cycle registered pulse.
// held and busy are registered levels that follow the FSM state.
module button_press_classifier #(
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int DCLICK_CYCLES = 25_000_000,
   parameter int CNT_W         = 26
) (
   input  logic                       clk,
   input  logic                       rst,
   button_press_classifier_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS1,
      GAP,
      PRESS2,
      LONG_HELD
   } state_t;

   localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DCLICK_TERM = CNT_W'(DCLICK_CYCLES - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             shortPress_q;
   logic             longPress_q;
   logic             doubleClick_q;
   logic             held_q;
   logic             busy_q;
   logic             pressEdge;
   logic             releaseEdge;

   // Simultaneous p_edge and n_edge cannot come from a healthy debouncer, so that
   // combination is masked out and the FSM behaves as if neither edge arrived.
   assign pressEdge   = bus.p_edge & ~bus.n_edge;
   assign releaseEdge = bus.n_edge & ~bus.p_edge;

   // Duration counter increment.
   // It saturates at the terminal value of the current timed state instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == PRESS1 && cnt_q != LONG_TERM) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (state_q == GAP && cnt_q != DCLICK_TERM) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Gesture FSM.
   // The counter clears on every state entry. Outputs are registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         shortPress_q  <= 1'b0;
         longPress_q   <= 1'b0;
         doubleClick_q <= 1'b0;
         held_q        <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         shortPress_q  <= 1'b0;
         longPress_q   <= 1'b0;
         doubleClick_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (pressEdge) begin
                  state_q <= PRESS1;
                  busy_q  <= 1'b1;
               end
            end
            PRESS1: begin
               if (releaseEdge) begin
                  cnt_q <= '0;
                  if (cnt_q == LONG_TERM) begin
                     // A release on the very cycle the press matures still counts as long.
                     longPress_q <= 1'b1;
                     state_q     <= IDLE;
                     busy_q      <= 1'b0;
                  end else begin
                     state_q <= GAP;
                  end
               end else if (cnt_q == LONG_TERM) begin
                  cnt_q       <= '0;
                  longPress_q <= 1'b1;
                  held_q      <= 1'b1;
                  state_q     <= LONG_HELD;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            GAP: begin
               if (pressEdge) begin
                  cnt_q <= '0;
                  if (cnt_q == DCLICK_TERM) begin
                     // The window closed on this edge: the first click is a short press
                     // and this press starts a fresh gesture.
                     shortPress_q <= 1'b1;
                     state_q      <= PRESS1;
                  end else begin
                     state_q <= PRESS2;
                  end
               end else if (cnt_q == DCLICK_TERM) begin
                  cnt_q        <= '0;
                  shortPress_q <= 1'b1;
                  state_q      <= IDLE;
                  busy_q       <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            PRESS2: begin
               cnt_q <= '0;
               if (releaseEdge) begin
                  doubleClick_q <= 1'b1;
                  state_q       <= IDLE;
                  busy_q        <= 1'b0;
               end
            end
            LONG_HELD: begin
               cnt_q <= '0;
               if (releaseEdge) begin
                  held_q  <= 1'b0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               cnt_q   <= '0;
               held_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.short_press  = shortPress_q;
   assign bus.long_press   = longPress_q;
   assign bus.double_click = doubleClick_q;
   assign bus.held         = held_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with small timing parameters.
// Outputs are checked as the vector {short, long, double, held, busy}.
module tb_button_press_classifier;

   localparam int LONG   = 20;
   localparam int DCLICK = 10;

   localparam logic [4:0] ZERO  = 5'b00000;
   localparam logic [4:0] BUSY  = 5'b00001;
   localparam logic [4:0] SHORT = 5'b10000;
   localparam logic [4:0] SHORT_BUSY = 5'b10001;
   localparam logic [4:0] LONGP = 5'b01011;
   localparam logic [4:0] HELD  = 5'b00011;
   localparam logic [4:0] DCLK  = 5'b00100;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   button_press_classifier_if bus ();

   button_press_classifier #(
      .LONG_CYCLES   (LONG),
      .DCLICK_CYCLES (DCLICK),
      .CNT_W         (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] observed();
      return {bus.short_press, bus.long_press, bus.double_click, bus.held, bus.busy};
   endfunction

   // Compares the output vector against the hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [4:0] expVec);
      logic [4:0] obs;
      obs = observed();
      compared++;
      assert (obs === expVec) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expVec);
      end
   endtask

   // Drives one cycle of edges, lets the DUT sample them, then checks just after the edge.
   task automatic applyStimulus(input logic p, input logic n, input logic [4:0] expVec,
                                input string tag);
      bus.p_edge = p;
      bus.n_edge = n;
      @(posedge clk);
      #1;
      bus.p_edge = 1'b0;
      bus.n_edge = 1'b0;
      checkOutput(tag, expVec);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      bus.p_edge = 1'b0;
      bus.n_edge = 1'b0;
      rst        = 1'b1;

      // Reset with random edges: outputs must stay quiet.
      for (int i = 0; i < 3; i++) begin
         bus.p_edge = 1'($urandom_range(1, 0));
         bus.n_edge = 1'($urandom_range(1, 0));
         @(posedge clk);
         #1;
         checkOutput("reset", ZERO);
      end
      bus.p_edge = 1'b0;
      bus.n_edge = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("post_reset", ZERO);

      // Idle ignores n_edge and the illegal both-high combination.
      applyStimulus(1'b0, 1'b1, ZERO, "idle_nedge");
      applyStimulus(1'b1, 1'b1, ZERO, "idle_both");

      // Short press: release after 5 cycles, short_press 10 cycles after release.
      applyStimulus(1'b1, 1'b0, BUSY, "sp_press");
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, BUSY, "sp_hold");
      applyStimulus(1'b0, 1'b1, BUSY, "sp_release");
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, BUSY, "sp_gap");
      applyStimulus(1'b0, 1'b0, SHORT, "sp_pulse");
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, ZERO, "sp_after");

      // Long press: long_press 20 cycles after p_edge, held until release.
      applyStimulus(1'b1, 1'b0, BUSY, "lp_press");
      for (int i = 0; i < LONG - 1; i++) applyStimulus(1'b0, 1'b0, BUSY, "lp_hold");
      applyStimulus(1'b0, 1'b0, LONGP, "lp_pulse");
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, HELD, "lp_held");
      applyStimulus(1'b1, 1'b0, HELD, "lp_held_pedge");
      applyStimulus(1'b0, 1'b1, ZERO, "lp_release");
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, ZERO, "lp_after");

      // Double click: p, n+4, p+6, n+4.
      applyStimulus(1'b1, 1'b0, BUSY, "dc_press1");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, BUSY, "dc_hold1");
      applyStimulus(1'b0, 1'b1, BUSY, "dc_release1");
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, BUSY, "dc_gap");
      applyStimulus(1'b1, 1'b0, BUSY, "dc_press2");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, BUSY, "dc_hold2");
      applyStimulus(1'b0, 1'b1, DCLK, "dc_pulse");
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, ZERO, "dc_after");

      // Gap boundary: second press 9 cycles after release is a double click.
      applyStimulus(1'b1, 1'b0, BUSY, "gb9_press1");
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, BUSY, "gb9_hold1");
      applyStimulus(1'b0, 1'b1, BUSY, "gb9_release1");
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, BUSY, "gb9_gap");
      applyStimulus(1'b1, 1'b0, BUSY, "gb9_press2");
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, BUSY, "gb9_hold2");
      applyStimulus(1'b0, 1'b1, DCLK, "gb9_pulse");
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, ZERO, "gb9_after");

      // Gap boundary: second press 10 cycles after release closes the window.
      applyStimulus(1'b1, 1'b0, BUSY, "gb10_press1");
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, BUSY, "gb10_hold1");
      applyStimulus(1'b0, 1'b1, BUSY, "gb10_release1");
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, BUSY, "gb10_gap");
      applyStimulus(1'b1, 1'b0, SHORT_BUSY, "gb10_short");
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, BUSY, "gb10_hold2");
      applyStimulus(1'b0, 1'b1, BUSY, "gb10_release2");
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, BUSY, "gb10_gap2");
      applyStimulus(1'b0, 1'b0, SHORT, "gb10_short2");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, ZERO, "gb10_after");

      // Asynchronous reset in the middle of the gap discards the gesture.
      applyStimulus(1'b1, 1'b0, BUSY, "ar_press");
      applyStimulus(1'b0, 1'b1, BUSY, "ar_release");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, BUSY, "ar_gap");
      #2;
      rst = 1'b1;
      #1;
      checkOutput("ar_busy_drop", ZERO);
      @(posedge clk);
      #1;
      checkOutput("ar_in_reset", ZERO);
      rst = 1'b0;
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, ZERO, "ar_after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
